// File: rtl/cram_pkg.sv
// Shared constants for the constant-RAM bank: named entry addresses,
// controller state encoding and the power-on contents.
package cram_pkg;

  localparam int CM_DATA_W = 20;
  localparam int CM_DEPTH  = 8;

  localparam int CM_SRC_BASE  = 3;
  localparam int CM_DST_BASE  = 4;
  localparam int CM_SRC_LAST  = 5;
  localparam int CM_SRC_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_READY  = 2'd1,
    ST_LOCKED = 2'd2
  } cram_state_t;

  // Entry i lives at [i*CM_DATA_W +: CM_DATA_W]; entry 7 is leftmost.
  localparam logic [CM_DEPTH*CM_DATA_W-1:0] CM_DEFAULTS = {
    20'd0,     // 7
    20'd118,   // 6 CM_SRC_WIDTH
    20'd8259,  // 5 CM_SRC_LAST
    20'd10000, // 4 CM_DST_BASE
    20'd0,     // 3 CM_SRC_BASE
    20'd0,     // 2
    20'd0,     // 1
    20'd0      // 0
  };

endpackage

// File: rtl/cram_rd_port.sv
// One registered read slice: range check, entry select, and valid/hold
// behaviour for a single read port of cram_bank.
module cram_rd_port #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rd_en,
  input  logic                    rd,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DEPTH*DATA_W-1:0] mem_flat,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    rd_oor
);

  logic              take;
  logic [DATA_W-1:0] sel;

  assign take   = rd_en & rd;
  assign rd_oor = take && (32'(addr) >= 32'(DEPTH));

  // Out-of-range addresses match no entry and therefore read as zero.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(addr) == 32'(i)) sel = mem_flat[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= take;
      if (take) rd_data <= sel;
    end
  end

endmodule

// File: rtl/cram_bank.sv
// Constant/parameter word bank: self-loads defaults after reset, serves NRD
// registered read ports, accepts host writes until locked.
module cram_bank
  import cram_pkg::*;
#(
  parameter int DATA_W = CM_DATA_W,
  parameter int DEPTH  = CM_DEPTH,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NRD    = 2,
  parameter logic [DEPTH*DATA_W-1:0] DEFAULTS = CM_DEFAULTS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NRD-1:0]        cm_r,
  input  logic [NRD*ADDR_W-1:0] cm_addr,
  output logic [NRD*DATA_W-1:0] cm_out,
  output logic [NRD-1:0]        cm_valid,
  input  logic                  cm_w,
  input  logic [ADDR_W-1:0]     cm_waddr,
  input  logic [DATA_W-1:0]     cm_wdata,
  input  logic                  cm_lock,
  input  logic                  cm_reinit,
  output logic                  cm_busy,
  output logic                  cm_locked,
  output logic                  cm_err,
  output logic [1:0]            dbg_state
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  cram_state_t               state, state_nxt;
  logic [ADDR_W-1:0]         cnt, cnt_nxt;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic [DEPTH*DATA_W-1:0]   mem_flat;
  logic [NRD-1:0]            rd_oor;
  logic                      rd_en, wr_in_range, wr_ok, wr_err, reinit_err;

  assign cm_busy   = (state == ST_INIT);
  assign cm_locked = (state == ST_LOCKED);
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_INIT: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end
      end
      ST_READY: begin
        if (cm_reinit) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end else if (cm_lock) begin
          state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: state_nxt = ST_LOCKED;
      default:   state_nxt = ST_INIT;
    endcase
  end

  assign wr_in_range = (32'(cm_waddr) < 32'(DEPTH));
  assign wr_ok       = cm_w && (state == ST_READY) && wr_in_range;
  assign wr_err      = cm_w && ((state == ST_LOCKED) ||
                                ((state == ST_READY) && !wr_in_range));
  assign reinit_err  = cm_reinit && (state == ST_LOCKED);

  // Reads sample the array before this edge's write lands, so a same-cycle
  // read of the written entry returns the old word.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) mem[cnt] <= DEFAULTS[cnt*DATA_W +: DATA_W];
    else if (wr_ok)       mem[cm_waddr] <= cm_wdata;
  end

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < DEPTH; i++) mem_flat[i*DATA_W +: DATA_W] = mem[i];
  end

  // Read handshake: cm_r[i] is a request sampled at the clock edge while not
  // busy; cm_valid[i] is high for exactly the following cycle with cm_out[i].
  assign rd_en = (state != ST_INIT);

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    cram_rd_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .clock    (clock),
      .reset_n  (reset_n),
      .rd_en    (rd_en),
      .rd       (cm_r[g]),
      .addr     (cm_addr[g*ADDR_W +: ADDR_W]),
      .mem_flat (mem_flat),
      .rd_data  (cm_out[g*DATA_W +: DATA_W]),
      .rd_valid (cm_valid[g]),
      .rd_oor   (rd_oor[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cm_err <= 1'b0;
    else          cm_err <= cm_err | wr_err | reinit_err | (|rd_oor);
  end

endmodule

// File: tb/tb_cram_bank.sv
// Bench for cram_bank: random traffic against a behavioural model for the
// 8-entry default instance, plus directed checks on a 6-entry instance.
module tb_cram_bank;
  import cram_pkg::*;

  logic        clock = 1'b0;
  logic        check_en = 1'b0;
  int          n_total = 0;
  int          n_pass  = 0;

  // 8-entry instance signals
  logic        reset_n;
  logic [1:0]  r;
  logic [5:0]  addr;
  logic [39:0] out;
  logic [1:0]  valid;
  logic        w, lock, reinit, busy, locked, err;
  logic [2:0]  waddr;
  logic [19:0] wdata;
  logic [1:0]  dbg;

  // 6-entry instance signals
  logic        rst6_n;
  logic [1:0]  r6;
  logic [5:0]  addr6;
  logic [39:0] out6;
  logic [1:0]  valid6;
  logic        w6, lock6, reinit6, busy6, locked6, err6;
  logic [2:0]  waddr6;
  logic [19:0] wdata6;
  logic [1:0]  dbg6;

  always #5 clock = ~clock;

  cram_bank dut (
    .clock(clock), .reset_n(reset_n), .cm_r(r), .cm_addr(addr),
    .cm_out(out), .cm_valid(valid), .cm_w(w), .cm_waddr(waddr),
    .cm_wdata(wdata), .cm_lock(lock), .cm_reinit(reinit), .cm_busy(busy),
    .cm_locked(locked), .cm_err(err), .dbg_state(dbg)
  );

  cram_bank #(.DEPTH(6), .DEFAULTS(CM_DEFAULTS[119:0])) dut6 (
    .clock(clock), .reset_n(rst6_n), .cm_r(r6), .cm_addr(addr6),
    .cm_out(out6), .cm_valid(valid6), .cm_w(w6), .cm_waddr(waddr6),
    .cm_wdata(wdata6), .cm_lock(lock6), .cm_reinit(reinit6), .cm_busy(busy6),
    .cm_locked(locked6), .cm_err(err6), .dbg_state(dbg6)
  );

  // Behavioural model of the 8-entry instance
  int unsigned def_vals [8] = '{0, 0, 0, 0, 10000, 8259, 118, 0};
  logic [19:0] m_mem [8];
  logic [19:0] m_out [2];
  logic [1:0]  m_valid;
  int          init_left;
  logic        m_locked, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    init_left = 8;
    m_out[0] = '0; m_out[1] = '0; m_valid = '0;
    m_locked = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int a;
    if (init_left > 0) begin
      init_left--;
      m_valid = '0;
      if (init_left == 0) for (int i = 0; i < 8; i++) m_mem[i] = 20'(def_vals[i]);
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (r[p]) begin
          a = int'(addr[p*3 +: 3]);
          m_valid[p] = 1'b1;
          if (a < 8) m_out[p] = m_mem[a];
          else begin m_out[p] = '0; m_err = 1'b1; end
        end else m_valid[p] = 1'b0;
      end
      if (w) begin
        if (m_locked) m_err = 1'b1;
        else m_mem[waddr] = wdata;
      end
      if (reinit) begin
        if (m_locked) m_err = 1'b1;
        else init_left = 8;
      end else if (lock) m_locked = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (check_en) model_step();
    #2;
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("busy",   busy,       init_left > 0);
      chk("locked", locked,     m_locked);
      chk("err",    err,        m_err);
      chk("valid",  valid,      m_valid);
      chk("out0",   out[19:0],  m_out[0]);
      chk("out1",   out[39:20], m_out[1]);
    end
  end

  task automatic idle_inputs();
    r = '0; addr = '0; w = 1'b0; waddr = '0; wdata = '0; lock = 1'b0; reinit = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      tick();
    end
    chk("wait_ready", busy, 0);
  endtask

  task automatic random_cycles(input int n, input bit allow_lock);
    for (int k = 0; k < n; k++) begin
      r      = 2'($urandom_range(0, 3));
      addr   = 6'($urandom_range(0, 63));
      w      = ($urandom_range(0, 9) < 3);
      waddr  = 3'($urandom_range(0, 7));
      wdata  = 20'($urandom & 32'hFFFFF);
      reinit = ($urandom_range(0, 99) < 2);
      lock   = allow_lock && ($urandom_range(0, 99) < 5);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; rst6_n = 1'b0;
    idle_inputs();
    r6 = '0; addr6 = '0; w6 = 1'b0; waddr6 = '0; wdata6 = '0; lock6 = 1'b0; reinit6 = 1'b0;
    tick(); tick();
    chk("rst_out",    out,    0);
    chk("rst_valid",  valid,  0);
    chk("rst_busy",   busy,   1);
    chk("rst_locked", locked, 0);
    chk("rst_err",    err,    0);

    // Init latency with a read request held from the first cycle
    reset_n = 1'b1;
    model_reset();
    check_en = 1'b1;
    r = 2'b01; addr = 6'(CM_DST_BASE);
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 7) chk("init_busy", busy, 1);
      if (c < 8) chk("init_valid", valid[0], 0);
      if (c == 8) chk("init_done", busy, 0);
      if (c == 9) begin
        chk("first_read", out[19:0], 10000);
        chk("first_valid", valid[0], 1);
      end
      tick();
    end

    // Dual-port read, then hold
    r = 2'b11; addr = {3'(CM_SRC_WIDTH), 3'(CM_SRC_LAST)};
    tick();
    chk("dual_p0", out[19:0], 8259);
    chk("dual_p1", out[39:20], 118);
    chk("dual_valid", valid, 2'b11);
    r = 2'b00;
    tick();
    chk("hold_valid", valid, 2'b00);
    chk("hold_p0", out[19:0], 8259);
    chk("hold_p1", out[39:20], 118);

    // Write with same-cycle read of the same entry
    r = 2'b01; addr = 6'd6; w = 1'b1; waddr = 3'd6; wdata = 20'd200;
    tick();
    w = 1'b0;
    chk("rd_old", out[19:0], 118);
    tick();
    chk("rd_new", out[19:0], 200);

    // Reinit restores defaults after exactly 8 busy cycles
    r = 2'b00; reinit = 1'b1;
    tick();
    reinit = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("reinit_busy", busy, 1);
      tick();
    end
    chk("reinit_done", busy, 0);
    r = 2'b01; addr = 6'd6;
    tick();
    chk("reinit_rd", out[19:0], 118);
    r = 2'b00;

    random_cycles(300, 1'b0);

    // Restore defaults, then lock
    wait_ready();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    wait_ready();
    lock = 1'b1;
    tick();
    lock = 1'b0; w = 1'b1; waddr = 3'(CM_SRC_BASE); wdata = 20'd55;
    tick();
    w = 1'b0;
    chk("lock_locked", locked, 1);
    chk("lock_err", err, 1);
    r = 2'b01; addr = 6'(CM_SRC_BASE);
    tick();
    chk("lock_rd", out[19:0], 0);
    r = 2'b00; reinit = 1'b1;
    tick();
    reinit = 1'b0;
    chk("lock_reinit_busy", busy, 0);
    chk("lock_reinit_locked", locked, 1);
    random_cycles(50, 1'b1);

    // 6-entry instance: out-of-range read and asynchronous reset mid-init
    rst6_n = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("d6_ready", busy6, 0);
    r6 = 2'b11; addr6 = {3'd7, 3'd4};
    tick();
    r6 = 2'b00;
    chk("d6_p0", out6[19:0], 10000);
    chk("d6_oor_out", out6[39:20], 0);
    chk("d6_oor_valid", valid6, 2'b11);
    chk("d6_oor_err", err6, 1);
    reinit6 = 1'b1;
    tick();
    reinit6 = 1'b0;
    tick(); tick(); tick();
    chk("d6_mid_busy", busy6, 1);
    rst6_n = 1'b0;
    #1;
    chk("d6_arst_out", out6, 0);
    chk("d6_arst_err", err6, 0);
    chk("d6_arst_busy", busy6, 1);
    chk("d6_arst_valid", valid6, 0);
    #1;
    rst6_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("d6_init_busy", busy6, 1);
      tick();
    end
    chk("d6_init_done", busy6, 0);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cram_bank.md
Name: cram_bank

Overview:
- Parametrised successor to the single-port constant memory. Holds the processor's constant/parameter words: source base, destination base, source last address, source width, and similar.
- Provides NRD independent registered read ports. Defaults are self-loaded after reset by an init sequencer.
- Provides a host write port for runtime reconfiguration, and a lock that freezes contents for the rest of operation.
- Sits beside the control unit, which reads constants during the address-generation phase.

Parameters:
- DATA_W, 20, word width.
- DEPTH, 8, number of entries; need not be a power of 2.
- ADDR_W, $clog2(DEPTH) (minimum 1), address width.
- NRD, 2, number of read ports.
- DEFAULTS, {DEPTH*DATA_W} packed vector, reset contents. Entry i is at [i*DATA_W +: DATA_W]. Default has entry 3=0, 4=10000, 5=8259, 6=118, all others 0.

Ports:
- clock  in  1  sole clock; rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cm_r  in  NRD  per-port read request.
- cm_addr  in  NRD*ADDR_W  per-port read address; port i at [i*ADDR_W +: ADDR_W].
- cm_out  out  NRD*DATA_W  per-port read data.
- cm_valid  out  NRD  per-port: cm_out updated this cycle.
- cm_w  in  1  write request.
- cm_waddr  in  ADDR_W  write address.
- cm_wdata  in  DATA_W  write data.
- cm_lock  in  1  pulse; freezes contents until reset.
- cm_reinit  in  1  pulse; reload DEFAULTS.
- cm_busy  out  1  init in progress; reads and writes not accepted.
- cm_locked  out  1  lock state.
- cm_err  out  1  sticky error flag.

Behaviour:
- Reset (async, reset_n=0): cm_out=0, cm_valid=0, cm_busy=1, cm_locked=0, cm_err=0. FSM enters INIT with counter=0. Array contents are undefined until INIT completes. Reset mid-INIT or mid-operation restarts INIT from entry 0.
- FSM states: INIT, READY, LOCKED.
  - INIT: each clock writes DEFAULTS[cnt] into entry cnt, then cnt++.
  - On the edge writing entry DEPTH-1: go to READY and cm_busy goes to 0. INIT therefore takes exactly DEPTH cycles after reset release.
  - READY: cm_lock=1 -> LOCKED. cm_reinit=1 -> INIT (cnt=0, cm_busy=1 next cycle). If both are asserted, cm_reinit wins.
  - LOCKED: cm_locked=1. cm_reinit is ignored and sets cm_err. Exit only via reset.
- Read, per port i, independent: in READY or LOCKED, cm_r[i]=1 samples cm_addr[i]. Next cycle: cm_out[i]=memory[addr] and cm_valid[i]=1. Latency 1.
  - cm_r[i]=0: cm_valid[i]=0 and cm_out[i] holds its last value.
  - Read during INIT: not accepted, cm_valid[i]=0, cm_out[i] holds. The requester retries after cm_busy falls.
  - Out-of-range read address (>=DEPTH): cm_out[i]=0, cm_valid[i]=1, cm_err set.
  - Any number of ports may read the same address in the same cycle.
- Write: in READY only, cm_w=1 with an in-range cm_waddr writes cm_wdata at the clock edge.
  - Same-cycle read of the same address returns the OLD data. The new value is visible to reads issued the following cycle.
  - cm_w during INIT: dropped silently, no error.
  - cm_w during LOCKED, or with an out-of-range address: dropped, cm_err set.
- cm_err: sticky; cleared only by reset.
- cm_lock during INIT is ignored.

Decomposition:
- Shared package cram_pkg holds:
  - Named address constants: CM_SRC_BASE=3, CM_DST_BASE=4, CM_SRC_LAST=5, CM_SRC_WIDTH=6.
  - State enum {ST_INIT, ST_READY, ST_LOCKED}.
  - The default DEFAULTS vector.
- One natural sub-module: cram_rd_port. It is the registered read slice (addr range check, data mux, valid/hold), instantiated NRD times through a generate loop. The FSM and array stay in cram_bank.

Test Plan:
- Release reset, assert cm_r[0] with addr 4 every cycle -> cm_busy=1 for cycles 0..7, cm_valid[0]=0 during those cycles. First read accepted in cycle 8; cm_out[0]=10000 with cm_valid[0]=1 in cycle 9.
- After init, same cycle port0 addr 5, port1 addr 6 -> next cycle cm_out[0]=8259, cm_out[1]=118, both valid. Drop cm_r -> valid=0, outputs hold 8259/118.
- Write addr 6 data 200 with port0 reading addr 6 in the same cycle -> cm_out[0]=118. Read addr 6 the next cycle -> 200.
- Pulse cm_lock, then write addr 3 data 55 -> cm_locked=1, cm_err=1, read addr 3 returns 0. Pulse cm_reinit -> no busy, still locked.
- Write addr 6 =200, then pulse cm_reinit in READY -> cm_busy=1 for 8 cycles. Read addr 6 afterwards returns 118.
- DEPTH=6 instance: read addr 7 -> cm_out=0, valid=1, cm_err=1. Assert reset_n=0 mid-INIT at cnt=3 -> all outputs reset immediately (async), and INIT restarts, taking 6 cycles.
